// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from video_timing_gen to the renderers and the TMDS encoder.
// The master side drives it and the slave side observes it.
interface video_timing_gen_if;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               lsync;
    logic               fsync;
    logic [15:0]        frame_cnt;

    modport master (output hpos, vpos, hsync, vsync, de, lsync, fsync, frame_cnt);
    modport slave  (input  hpos, vpos, hsync, vsync, de, lsync, fsync, frame_cnt);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing source. Coordinates are negative in blanking and zero-based in the active area.
// Every output is registered from the next counter value, so strobes stay aligned with hpos/vpos.
module video_timing_gen #(
    parameter int HRES     = 1280,
    parameter int VRES     = 720,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    video_timing_gen_if.master vid
);
    localparam int H_START  = -(H_FP + H_SYNC + H_BP);
    localparam int H_END    = HRES - 1;
    localparam int V_START  = -(V_FP + V_SYNC + V_BP);
    localparam int V_END    = VRES - 1;
    localparam int HS_FIRST = H_START + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_START + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    if (H_START < -2048 || H_END > 2047 || V_START < -2048 || V_END > 2047) begin : g_range_check
        $error("video_timing_gen: timing constants do not fit 12-bit signed coordinates");
    end

    localparam logic signed [11:0] H_START_C  = 12'(H_START);
    localparam logic signed [11:0] H_END_C    = 12'(H_END);
    localparam logic signed [11:0] V_START_C  = 12'(V_START);
    localparam logic signed [11:0] V_END_C    = 12'(V_END);
    localparam logic signed [11:0] HS_FIRST_C = 12'(HS_FIRST);
    localparam logic signed [11:0] HS_LAST_C  = 12'(HS_LAST);
    localparam logic signed [11:0] VS_FIRST_C = 12'(VS_FIRST);
    localparam logic signed [11:0] VS_LAST_C  = 12'(VS_LAST);

    logic signed [11:0] hpos_q, hpos_d;
    logic signed [11:0] vpos_q, vpos_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               lsync_q, lsync_d;
    logic               fsync_q, fsync_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    always_comb begin
        hpos_d = hpos_q + 12'sd1;
        vpos_d = vpos_q;
        if (hpos_q == H_END_C) begin
            hpos_d = H_START_C;
            vpos_d = (vpos_q == V_END_C) ? V_START_C : vpos_q + 12'sd1;
        end

        // Decode from the next coordinates so the registered strobes land with them.
        hsync_d     = ((hpos_d >= HS_FIRST_C) && (hpos_d <= HS_LAST_C)) ? SYNC_POL : !SYNC_POL;
        vsync_d     = ((vpos_d >= VS_FIRST_C) && (vpos_d <= VS_LAST_C)) ? SYNC_POL : !SYNC_POL;
        de_d        = !hpos_d[11] && !vpos_d[11];
        lsync_d     = (hpos_d == H_START_C);
        fsync_d     = lsync_d && (vpos_d == V_START_C);
        frame_cnt_d = fsync_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hpos_q      <= H_START_C;
            vpos_q      <= V_START_C;
            hsync_q     <= !SYNC_POL;
            vsync_q     <= !SYNC_POL;
            de_q        <= 1'b0;
            lsync_q     <= 1'b0;
            fsync_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            lsync_q     <= lsync_d;
            fsync_q     <= fsync_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vid.hpos      = hpos_q;
    assign vid.vpos      = vpos_q;
    assign vid.hsync     = hsync_q;
    assign vid.vsync     = vsync_q;
    assign vid.de        = de_q;
    assign vid.lsync     = lsync_q;
    assign vid.fsync     = fsync_q;
    assign vid.frame_cnt = frame_cnt_q;
endmodule
